// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, state encoding,
// immediate-extension selects and the default memory timeout.
package ctrl_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 16;

   localparam logic [5:0] OP_ALU_R = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h01;
   localparam logic [5:0] OP_ORI   = 6'h02;
   localparam logic [5:0] OP_SLLI  = 6'h03;
   localparam logic [5:0] OP_MOVI  = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h06;
   localparam logic [5:0] OP_BEQ   = 6'h07;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [1:0] EXT_IMM5  = 2'd0;
   localparam logic [1:0] EXT_IMM15 = 2'd1;
   localparam logic [1:0] EXT_IMM20 = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt
   } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode lookup: extension control plus the instruction-class
// flags the sequencer needs for EXEC/MEM/WB routing.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output logic [1:0] ext_sel,
   output logic       ext_sign_ena,
   output logic       is_mem,
   output logic       is_store,
   output logic       is_branch,
   output logic       has_wb,
   output logic       legal
);

   always_comb begin
      ext_sel      = EXT_IMM5;
      ext_sign_ena = 1'b0;
      is_mem       = 1'b0;
      is_store     = 1'b0;
      is_branch    = 1'b0;
      has_wb       = 1'b0;
      legal        = 1'b1;
      case (opcode)
         OP_ALU_R: has_wb = 1'b1;
         OP_ADDI: begin
            ext_sel      = EXT_IMM15;
            ext_sign_ena = 1'b1;
            has_wb       = 1'b1;
         end
         OP_ORI: begin
            ext_sel = EXT_IMM15;
            has_wb  = 1'b1;
         end
         OP_SLLI: begin
            ext_sel = EXT_IMM5;
            has_wb  = 1'b1;
         end
         OP_MOVI: begin
            ext_sel      = EXT_IMM20;
            ext_sign_ena = 1'b1;
            has_wb       = 1'b1;
         end
         OP_LW: begin
            ext_sel      = EXT_IMM15;
            ext_sign_ena = 1'b1;
            is_mem       = 1'b1;
            has_wb       = 1'b1;
         end
         OP_SW: begin
            ext_sel      = EXT_IMM15;
            ext_sign_ena = 1'b1;
            is_mem       = 1'b1;
            is_store     = 1'b1;
         end
         OP_BEQ: begin
            ext_sel      = EXT_IMM15;
            ext_sign_ena = 1'b1;
            is_branch    = 1'b1;
         end
         OP_HALT: ;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: FETCH/DECODE/EXEC/MEM/WB with bounded memory waits
// and sticky halt/illegal/bus-error status.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic        im_ready,
   input  logic        dm_ready,
   input  logic        zero_flag,
   output logic        im_req,
   output logic        ir_load,
   output logic        pc_inc,
   output logic        pc_branch,
   output logic        dm_req,
   output logic        dm_we,
   output logic        reg_we,
   output logic        alu_src_imm,
   output logic [1:0]  ext_sel,
   output logic        ext_sign_ena,
   output logic        halted,
   output logic        illegal,
   output logic        bus_err
);

   localparam int unsigned   CntW    = $clog2(TIMEOUT) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      ext_sel_q, ext_sel_d;
   logic            ext_sign_q, ext_sign_d;
   logic            illegal_q, illegal_d;
   logic            bus_err_q, bus_err_d;
   logic            use_imm_q, use_imm_d;
   logic            is_mem_q, is_mem_d;
   logic            is_store_q, is_store_d;
   logic            is_branch_q, is_branch_d;
   logic            has_wb_q, has_wb_d;

   logic [5:0] opcode;
   logic [1:0] dec_ext_sel;
   logic       dec_ext_sign, dec_is_mem, dec_is_store, dec_is_branch, dec_has_wb, dec_legal;
   logic       unused_ir;

   assign opcode    = ir[31:26];
   assign unused_ir = ^ir[25:0];

   ctrl_decode u_decode (
      .opcode       (opcode),
      .ext_sel      (dec_ext_sel),
      .ext_sign_ena (dec_ext_sign),
      .is_mem       (dec_is_mem),
      .is_store     (dec_is_store),
      .is_branch    (dec_is_branch),
      .has_wb       (dec_has_wb),
      .legal        (dec_legal)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      ext_sel_d   = ext_sel_q;
      ext_sign_d  = ext_sign_q;
      illegal_d   = illegal_q;
      bus_err_d   = bus_err_q;
      use_imm_d   = use_imm_q;
      is_mem_d    = is_mem_q;
      is_store_d  = is_store_q;
      is_branch_d = is_branch_q;
      has_wb_d    = has_wb_q;
      im_req      = 1'b0;
      ir_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_branch   = 1'b0;
      dm_req      = 1'b0;
      dm_we       = 1'b0;
      reg_we      = 1'b0;
      alu_src_imm = 1'b0;

      case (state_q)
         StIdle: if (start) state_d = StFetch;
         StFetch: begin
            im_req = 1'b1;
            if (im_ready) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = StDecode;
            end else if (cnt_q == CntLast) begin
               state_d   = StHalt;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDecode: begin
            if (!dec_legal) begin
               state_d   = StHalt;
               illegal_d = 1'b1;
            end else if (opcode == OP_HALT) begin
               state_d = StHalt;
            end else begin
               // ALU_R has no immediate, so the extension unit keeps its last setting
               if (opcode != OP_ALU_R) begin
                  ext_sel_d  = dec_ext_sel;
                  ext_sign_d = dec_ext_sign;
               end
               use_imm_d   = (opcode != OP_ALU_R);
               is_mem_d    = dec_is_mem;
               is_store_d  = dec_is_store;
               is_branch_d = dec_is_branch;
               has_wb_d    = dec_has_wb;
               state_d     = StExec;
            end
         end
         StExec: begin
            alu_src_imm = use_imm_q;
            if (is_branch_q) begin
               pc_branch = zero_flag;
               state_d   = StFetch;
            end else if (is_mem_q) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            dm_req = 1'b1;
            dm_we  = is_store_q;
            if (dm_ready) begin
               state_d = has_wb_q ? StWb : StFetch;
            end else if (cnt_q == CntLast) begin
               state_d   = StHalt;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWb: begin
            reg_we  = 1'b1;
            state_d = StFetch;
         end
         StHalt: ;
         default: state_d = StIdle;
      endcase

      // Strobes are Mealy on state_q, so mask them while reset is being applied
      if (rst) begin
         im_req      = 1'b0;
         ir_load     = 1'b0;
         pc_inc      = 1'b0;
         pc_branch   = 1'b0;
         dm_req      = 1'b0;
         dm_we       = 1'b0;
         reg_we      = 1'b0;
         alu_src_imm = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         ext_sel_q   <= EXT_IMM5;
         ext_sign_q  <= 1'b0;
         illegal_q   <= 1'b0;
         bus_err_q   <= 1'b0;
         use_imm_q   <= 1'b0;
         is_mem_q    <= 1'b0;
         is_store_q  <= 1'b0;
         is_branch_q <= 1'b0;
         has_wb_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ext_sel_q   <= ext_sel_d;
         ext_sign_q  <= ext_sign_d;
         illegal_q   <= illegal_d;
         bus_err_q   <= bus_err_d;
         use_imm_q   <= use_imm_d;
         is_mem_q    <= is_mem_d;
         is_store_q  <= is_store_d;
         is_branch_q <= is_branch_d;
         has_wb_q    <= has_wb_d;
      end
   end

   assign ext_sel      = ext_sel_q;
   assign ext_sign_ena = ext_sign_q;
   assign halted       = (state_q == StHalt);
   assign illegal      = illegal_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction timing model pushes
// expected strobe events; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

   localparam int TO = 16;

   localparam int EvFetch  = 0;
   localparam int EvAluImm = 1;
   localparam int EvBranch = 2;
   localparam int EvMem    = 3;
   localparam int EvWb     = 4;
   localparam int EvHalt   = 5;
   localparam int EvProto  = 6;

   typedef struct {
      int         cyc;
      int         kind;
      logic [3:0] data;
   } exp_t;

   logic        clk, rst, start, im_ready, dm_ready, zero_flag;
   logic [31:0] ir;
   logic        im_req, ir_load, pc_inc, pc_branch, dm_req, dm_we, reg_we, alu_src_imm;
   logic [1:0]  ext_sel;
   logic        ext_sign_ena, halted, illegal, bus_err;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        halted_prev = 1'b0;
   logic [1:0]  m_sel;
   logic        m_sign;
   bit          st;

   multicycle_ctrl #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .ir           (ir),
      .im_ready     (im_ready),
      .dm_ready     (dm_ready),
      .zero_flag    (zero_flag),
      .im_req       (im_req),
      .ir_load      (ir_load),
      .pc_inc       (pc_inc),
      .pc_branch    (pc_branch),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .reg_we       (reg_we),
      .alu_src_imm  (alu_src_imm),
      .ext_sel      (ext_sel),
      .ext_sign_ena (ext_sign_ena),
      .halted       (halted),
      .illegal      (illegal),
      .bus_err      (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(int k);
      case (k)
         EvFetch:  return "fetch";
         EvAluImm: return "alu_imm";
         EvBranch: return "branch";
         EvMem:    return "mem";
         EvWb:     return "wb";
         EvHalt:   return "halt";
         default:  return "protocol";
      endcase
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, expv);
      end
   endfunction

   function automatic void observe(int k, logic [3:0] d);
      exp_t e;
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
         errors++;
         $display("FAIL unexpected_%s at cyc %0d: got data %h, expected no event", kname(k), cyc, d);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.data !== d) begin
            errors++;
            $display("FAIL event at cyc %0d: got %s/%h, expected %s/%h",
                     cyc, kname(k), d, kname(e.kind), e.data);
         end
      end
   endfunction

   function automatic void push(int t0, int lim, int off, int kind, logic [3:0] data);
      if (off < lim) q.push_back('{cyc: t0 + off, kind: kind, data: data});
   endfunction

   // Extension setting implied by the opcode table (ALU_R never reaches here)
   function automatic void model_ext(logic [5:0] op);
      case (op)
         6'h02:   begin m_sel = 2'd1; m_sign = 1'b0; end
         6'h03:   begin m_sel = 2'd0; m_sign = 1'b0; end
         6'h04:   begin m_sel = 2'd2; m_sign = 1'b1; end
         default: begin m_sel = 2'd1; m_sign = 1'b1; end
      endcase
   endfunction

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_%s at cyc %0d: got nothing, expected data %h",
                  kname(q[0].kind), q[0].cyc, q[0].data);
         void'(q.pop_front());
      end
      if (ir_load || pc_inc) observe(EvFetch, {ir_load, pc_inc, im_req, 1'b0});
      if (alu_src_imm) observe(EvAluImm, {1'b0, ext_sel, ext_sign_ena});
      if (pc_branch) observe(EvBranch, {1'b0, ext_sel, ext_sign_ena});
      if (dm_req && dm_ready) observe(EvMem, {dm_we, ext_sel, ext_sign_ena});
      if (reg_we) observe(EvWb, {1'b0, ext_sel, ext_sign_ena});
      if (halted && !halted_prev) observe(EvHalt, {illegal, bus_err, 2'b00});
      if ((im_req && dm_req) || (dm_we && !dm_req) || (halted && (im_req || dm_req)))
         observe(EvProto, 4'hF);
      halted_prev <= halted;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b1; im_ready = 1'b1; dm_ready = 1'b1;
      @(negedge clk);
      chk("strobes_in_reset",
          {im_req, ir_load, pc_inc, pc_branch, dm_req, dm_we, reg_we, alu_src_imm}, 0);
      step();
      rst = 1'b0; start = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
      m_sel = 2'd0; m_sign = 1'b0;
      @(negedge clk);
      chk("reset_flags", {halted, illegal, bus_err}, 0);
      chk("reset_ext", {ext_sel, ext_sign_ena}, 0);
      chk("reset_strobes",
          {im_req, ir_load, pc_inc, pc_branch, dm_req, dm_we, reg_we, alu_src_imm}, 0);
   endtask

   task automatic start_prog();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Drives one instruction from its first FETCH cycle; w/d are the ready delays
   // (>= TO means ready never comes), rst_off >= 0 stops driving at that offset.
   task automatic run_instr(input logic [5:0] op, input logic [19:0] imm, input int w,
                            input int d, input logic zf, input int rst_off, output bit stopped);
      int t0, n, lim, fend, m0, mend;
      bit mem_op, legal;
      logic [2:0] xd;
      t0      = cyc;
      lim     = (rst_off >= 0) ? rst_off : 32'h3fff_ffff;
      stopped = 1'b0;
      m0      = w + 3;
      mem_op  = (op == 6'h05 || op == 6'h06);
      legal   = (op <= 6'h07) || (op == 6'h3F);
      fend    = (w >= TO) ? TO - 1 : w;
      mend    = (d >= TO) ? m0 + TO - 1 : m0 + d;
      ir      = {op, 6'($urandom), imm};
      n       = 0;
      if (w >= TO) begin
         push(t0, lim, TO, EvHalt, 4'b0100);
         n = TO; stopped = 1'b1;
      end else begin
         push(t0, lim, w, EvFetch, 4'b1110);
         if (!legal) begin
            push(t0, lim, w + 2, EvHalt, 4'b1000);
            n = w + 2; stopped = 1'b1;
         end else if (op == 6'h3F) begin
            push(t0, lim, w + 2, EvHalt, 4'b0000);
            n = w + 2; stopped = 1'b1;
         end else begin
            if (op != 6'h00 && w + 1 < lim) model_ext(op);
            xd = {m_sel, m_sign};
            if (op != 6'h00) push(t0, lim, w + 2, EvAluImm, {1'b0, xd});
            if (op == 6'h07) begin
               if (zf) push(t0, lim, w + 2, EvBranch, {1'b0, xd});
               n = w + 3;
            end else if (mem_op) begin
               if (d >= TO) begin
                  push(t0, lim, m0 + TO, EvHalt, 4'b0100);
                  n = m0 + TO; stopped = 1'b1;
               end else begin
                  push(t0, lim, m0 + d, EvMem, {op == 6'h06, xd});
                  if (op == 6'h05) begin
                     push(t0, lim, m0 + d + 1, EvWb, {1'b0, xd});
                     n = m0 + d + 2;
                  end else begin
                     n = m0 + d + 1;
                  end
               end
            end else begin
               push(t0, lim, w + 3, EvWb, {1'b0, xd});
               n = w + 4;
            end
         end
      end
      if (rst_off >= 0) n = rst_off;
      for (int k = 0; k < n; k++) begin
         im_ready  = (k <= fend) ? (k == w) : 1'($urandom);
         dm_ready  = (mem_op && k >= m0 && k <= mend) ? (k == m0 + d) : 1'($urandom);
         zero_flag = (k == w + 2) ? zf : 1'($urandom);
         start     = 1'($urandom);
         step();
      end
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; im_ready = 1'b0; dm_ready = 1'b0; zero_flag = 1'b0;
      ir = '0; m_sel = 2'd0; m_sign = 1'b0;
      do_reset();
      start_prog();

      run_instr(6'h01, 20'h0FFFF, 0, 0, 1'b0, -1, st);   // ADDI
      run_instr(6'h05, 20'h00123, 0, 3, 1'b0, -1, st);   // LW, 3 wait cycles
      run_instr(6'h07, 20'h00010, 0, 0, 1'b1, -1, st);   // BEQ taken
      run_instr(6'h07, 20'h00010, 0, 0, 1'b0, -1, st);   // BEQ not taken
      run_instr(6'h06, 20'h00044, 2, 1, 1'b0, -1, st);   // SW
      run_instr(6'h02, 20'h07FFF, 1, 0, 1'b0, -1, st);   // ORI
      run_instr(6'h03, 20'h0001F, 0, 0, 1'b0, -1, st);   // SLLI
      run_instr(6'h04, 20'hFFFFF, 0, 0, 1'b0, -1, st);   // MOVI
      run_instr(6'h00, 20'h00000, 0, 0, 1'b0, -1, st);   // ALU_R holds MOVI ext
      run_instr(6'h01, 20'h00001, TO - 1, 0, 1'b0, -1, st);  // im_ready on last cycle
      run_instr(6'h05, 20'h00002, 0, TO - 1, 1'b0, -1, st);  // dm_ready on last cycle

      for (int i = 0; i < 40; i++) begin
         run_instr(6'($urandom_range(0, 7)), 20'($urandom),
                   ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2)),
                   ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3)),
                   1'($urandom), -1, st);
      end

      run_instr(6'h3F, 20'h0, 1, 0, 1'b0, -1, st);
      @(negedge clk);
      chk("halt_op_flags", {halted, illegal, bus_err}, 3'b100);
      repeat (4) begin
         start = 1'b1; im_ready = 1'b1; dm_ready = 1'b1;
         step();
      end
      @(negedge clk);
      chk("halt_absorbing", {halted, illegal, bus_err}, 3'b100);

      do_reset();
      start_prog();
      run_instr(6'h2A, 20'h0, 1, 0, 1'b0, -1, st);
      @(negedge clk);
      chk("illegal_flags", {halted, illegal, bus_err}, 3'b110);

      do_reset();
      start_prog();
      run_instr(6'h01, 20'h0, TO, 0, 1'b0, -1, st);
      @(negedge clk);
      chk("fetch_timeout_flags", {halted, illegal, bus_err}, 3'b101);

      do_reset();
      start_prog();
      run_instr(6'h06, 20'h0, 0, TO, 1'b0, -1, st);
      @(negedge clk);
      chk("mem_timeout_flags", {halted, illegal, bus_err}, 3'b101);

      do_reset();
      start_prog();
      run_instr(6'h05, 20'h0, 0, 10, 1'b0, 5, st);   // reset lands mid MEM wait
      do_reset();

      repeat (3) step();
      while (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL leftover_%s: got nothing, expected data %h at cyc %0d",
                  kname(q[0].kind), q[0].data, q[0].cyc);
         void'(q.pop_front());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
